timestamp_unit: RTL

//  Free-running seconds/nanoseconds time-of-day counter for packet timestamping.

---
 rtl/timestamp_pkg.sv | 20 ++
 rtl/ts_capture_channel.sv | 55 +++++
 rtl/timestamp_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/timestamp_pkg.sv
// Shared types and elaboration helpers for the time-of-day counter and its capture channels.
// The nominal increment is computed here so that every instance derives it the same way.
package timestamp_pkg;

  localparam int unsigned NS_PER_SEC = 1_000_000_000;

  typedef struct packed {
    logic [31:0] sec;
    logic [31:0] nsec;
  } ts_t;

  // Nanoseconds per clock in fixed point, truncated toward zero.
  function automatic logic [63:0] calc_inc(input longint unsigned freq_hz,
                                           input int unsigned frac_bits);
    logic [63:0] scaled;
    scaled = 64'(NS_PER_SEC) << frac_bits;
    return scaled / 64'(freq_hz);
  endfunction

endpackage

// File: rtl/ts_capture_channel.sv
// One capture slot: latches the presented time on a strobe and tracks
// whether software has consumed it (valid) or lost an earlier value (ovr).
module ts_capture_channel
  import timestamp_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  ts_t  now,
  input  logic stb,
  input  logic ack,
  output ts_t  cap,
  output logic valid,
  output logic ovr
);

  ts_t  cap_reg, cap_next;
  logic valid_reg, valid_next;
  logic ovr_reg, ovr_next;

  always_comb begin
    cap_next   = cap_reg;
    valid_next = valid_reg;
    ovr_next   = ovr_reg;
    if (stb) begin
      cap_next   = now;
      valid_next = 1'b1;
      // An ack in the same cycle consumes the old value, so nothing is lost.
      if (ack) begin
        ovr_next = 1'b0;
      end else if (valid_reg) begin
        ovr_next = 1'b1;
      end
    end else if (ack) begin
      valid_next = 1'b0;
      ovr_next   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cap_reg   <= '0;
      valid_reg <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      cap_reg   <= cap_next;
      valid_reg <= valid_next;
      ovr_reg   <= ovr_next;
    end
  end

  assign cap   = cap_reg;
  assign valid = valid_reg;
  assign ovr   = ovr_reg;

endmodule

// File: rtl/timestamp_unit.sv
// Free-running seconds/nanoseconds counter with a fractional, trimmable increment,
// software time load, and per-channel capture registers for packet timestamping.
module timestamp_unit
  import timestamp_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int FRAC_BITS   = 16,
  parameter int NUM_CAP     = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   set_valid,
  input  logic [31:0]            set_sec,
  input  logic [29:0]            set_nsec,
  input  logic                   inc_wr,
  input  logic [8+FRAC_BITS-1:0] inc_value,
  input  logic [NUM_CAP-1:0]     cap_stb,
  input  logic [NUM_CAP-1:0]     cap_ack,
  output logic [31:0]            seconds,
  output logic [31:0]            nanoseconds,
  output logic                   pps,
  output logic [NUM_CAP*32-1:0]  cap_sec,
  output logic [NUM_CAP*32-1:0]  cap_nsec,
  output logic [NUM_CAP-1:0]     cap_valid,
  output logic [NUM_CAP-1:0]     cap_ovr
);

  localparam int INC_W = 8 + FRAC_BITS;
  localparam int ACC_W = 30 + FRAC_BITS;

  localparam logic [63:0]      INC_NOM_64 = calc_inc(64'(CLK_FREQ_HZ), FRAC_BITS);
  localparam logic [INC_W-1:0] INC_NOM    = INC_NOM_64[INC_W-1:0];
  localparam logic [63:0]      ROLL_64    = 64'(NS_PER_SEC) << FRAC_BITS;
  localparam logic [ACC_W:0]   ROLL       = ROLL_64[ACC_W:0];

  if (INC_NOM_64 >= (64'd256 << FRAC_BITS)) begin : g_bad_freq
    $error("timestamp_unit: CLK_FREQ_HZ too low, nominal increment must be below 256 ns");
  end

  if (NUM_CAP < 1 || NUM_CAP > 8) begin : g_bad_num_cap
    $error("timestamp_unit: NUM_CAP must be in 1..8");
  end

  logic [31:0]      sec_reg, sec_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [INC_W-1:0] inc_reg, inc_next;
  logic             pps_reg, pps_next;

  logic [ACC_W:0]   sum;
  logic [29:0]      set_nsec_clamped;

  assign set_nsec_clamped = (set_nsec >= 30'(NS_PER_SEC)) ? 30'(NS_PER_SEC - 1) : set_nsec;

  always_comb begin
    sum      = {1'b0, acc_reg} + {{(ACC_W + 1 - INC_W){1'b0}}, inc_reg};
    sec_next = sec_reg;
    acc_next = acc_reg;
    inc_next = inc_reg;
    pps_next = 1'b0;
    if (inc_wr) begin
      inc_next = inc_value;
    end
    // A software load replaces the tick of this cycle and starts on an exact nanosecond.
    if (set_valid) begin
      sec_next = set_sec;
      acc_next = {set_nsec_clamped, {FRAC_BITS{1'b0}}};
    end else if (sum >= ROLL) begin
      acc_next = ACC_W'(sum - ROLL);
      sec_next = sec_reg + 32'd1;
      pps_next = 1'b1;
    end else begin
      acc_next = sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sec_reg <= '0;
      acc_reg <= '0;
      inc_reg <= INC_NOM;
      pps_reg <= 1'b0;
    end else begin
      sec_reg <= sec_next;
      acc_reg <= acc_next;
      inc_reg <= inc_next;
      pps_reg <= pps_next;
    end
  end

  assign seconds     = sec_reg;
  assign nanoseconds = {2'b00, acc_reg[ACC_W-1 -: 30]};
  assign pps         = pps_reg;

  ts_t now_ts;
  assign now_ts.sec  = seconds;
  assign now_ts.nsec = nanoseconds;

  // Channels see the registered time, so a strobe records the value visible before its edge.
  for (genvar gi = 0; gi < NUM_CAP; gi++) begin : g_cap
    ts_t cap_ts;

    ts_capture_channel u_channel (
      .clk     (clk),
      .reset_n (reset_n),
      .now     (now_ts),
      .stb     (cap_stb[gi]),
      .ack     (cap_ack[gi]),
      .cap     (cap_ts),
      .valid   (cap_valid[gi]),
      .ovr     (cap_ovr[gi])
    );

    assign cap_sec[32*gi +: 32]  = cap_ts.sec;
    assign cap_nsec[32*gi +: 32] = cap_ts.nsec;
  end

endmodule
